cpu_sequencer: RTL and testbench

Multi-cycle execution controller for the 4-bit accumulator CPU. It replaces the free-running phase toggle and the combinational decoder with one FSM that sequences fetch, optional RAM wait states and execute, and drives every datapath enable: PC, accumulator, flags, RAM, bus drivers and outputs. It also provides run/halt control so the core can be stopped between instructions.

---
 rtl/cpu_sequencer.sv | 153 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH / MWAIT / EXEC controller for the 4-bit
// accumulator CPU. It drives every datapath strobe and bus enable, and
// provides run/halt control between instructions.
//
// Optional feature macro: SINGLE_STEP_EN adds the "step" input. A rising
// edge on step while idle with run=0 executes exactly one instruction.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | halted between instructions; all outputs 0
// FETCH | opcode valid on instr; picks MWAIT or EXEC; outputs 0
// MWAIT | RAM wait states for memory ops; bus source and S already driven
// EXEC  | strobes fire; targets capture on the edge that ends this state
module cpu_sequencer #(
    parameter int unsigned RAM_WAIT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] instr,
    input  logic       c_flag,
    input  logic       z_flag,
    input  logic       run,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       phase,
    output logic       IncPC,
    output logic       LoadPC,
    output logic       LoadA,
    output logic       LoadFlags,
    output logic       LoadOut,
    output logic [2:0] S,
    output logic       csRAM,
    output logic       weRAM,
    output logic       oeOprnd,
    output logic       oeALU,
    output logic       oeIN,
    output logic [1:0] state
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] FETCH = 2'b01;
    localparam logic [1:0] MWAIT = 2'b10;
    localparam logic [1:0] EXEC  = 2'b11;

    // Counter is loaded with RAM_WAIT-1 so the terminal count is zero.
    localparam logic [2:0] WAIT_LOAD = (RAM_WAIT > 0) ? 3'(RAM_WAIT - 1) : 3'd0;
    localparam bit         HAS_WAIT  = (RAM_WAIT > 0);

    logic [1:0] state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       is_mem;
    logic       go;

    assign is_mem = (instr == 4'h3) || (instr == 4'h6) || (instr == 4'h7) ||
                    (instr == 4'hB) || (instr == 4'hF);

`ifdef SINGLE_STEP_EN
    logic step_q;

    // Registered copy of step for rising-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) step_q <= 1'b0;
        else       step_q <= step;
    end

    assign go = run | (step & ~step_q);
`else
    assign go = run;
`endif

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE:  if (go) state_d = FETCH;
            FETCH: begin
                if (HAS_WAIT && is_mem) begin
                    state_d = MWAIT;
                    wait_d  = WAIT_LOAD;
                end else begin
                    state_d = EXEC;
                end
            end
            MWAIT: begin
                if (wait_q == 3'd0) state_d = EXEC;
                else                wait_d  = wait_q - 3'd1;
            end
            default: state_d = run ? FETCH : IDLE;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Output decode from registered state and the held opcode.
    always_comb begin
        logic active, exec, take;
        active    = state_q[1];
        exec      = (state_q == EXEC);
        phase     = active;
        IncPC     = 1'b0;
        LoadPC    = 1'b0;
        LoadA     = 1'b0;
        LoadFlags = 1'b0;
        LoadOut   = 1'b0;
        S         = 3'b000;
        csRAM     = 1'b0;
        weRAM     = 1'b0;
        oeOprnd   = 1'b0;
        oeALU     = 1'b0;
        oeIN      = 1'b0;
        take      = 1'b0;
        if (active) begin
            case (instr)
                4'h2: begin oeOprnd = 1'b1; S = 3'b001; LoadFlags = exec; end
                4'h3: begin csRAM = 1'b1; S = 3'b001; LoadFlags = exec; end
                4'h4: begin oeOprnd = 1'b1; LoadA = exec; end
                4'h5: begin oeIN = 1'b1; LoadA = exec; end
                4'h6: begin csRAM = 1'b1; LoadA = exec; end
                4'h7: begin csRAM = 1'b1; weRAM = 1'b1; oeALU = 1'b1; S = 3'b100; end
                4'hA: begin oeOprnd = 1'b1; S = 3'b010; LoadA = exec; LoadFlags = exec; end
                4'hB: begin csRAM = 1'b1; S = 3'b010; LoadA = exec; LoadFlags = exec; end
                4'hD: begin oeALU = 1'b1; S = 3'b100; LoadOut = exec; end
                4'hE: begin oeOprnd = 1'b1; S = 3'b011; LoadA = exec; end
                4'hF: begin csRAM = 1'b1; S = 3'b011; LoadA = exec; end
                default: ;
            endcase
            case (instr)
                4'h0:    take = c_flag;
                4'h1:    take = ~c_flag;
                4'h8:    take = z_flag;
                4'h9:    take = ~z_flag;
                4'hC:    take = 1'b1;
                default: take = 1'b0;
            endcase
        end
        LoadPC = exec & take;
        IncPC  = exec & ~take;
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer with RAM_WAIT=2. An instruction-level
// reference model gives the expected cycle sequence of each instruction and
// a per-opcode table gives the expected outputs in each cycle.
module tb_cpu_sequencer;

    localparam int RW = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] instr = 4'h0;
    logic       c_flag = 1'b0;
    logic       z_flag = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       phase, IncPC, LoadPC, LoadA, LoadFlags, LoadOut;
    logic [2:0] S;
    logic       csRAM, weRAM, oeOprnd, oeALU, oeIN;
    logic [1:0] state;
    logic [15:0] obs;

    int total = 0;
    int bad   = 0;

    cpu_sequencer #(.RAM_WAIT(RW)) dut (
        .clock(clock), .reset(reset), .instr(instr), .c_flag(c_flag),
        .z_flag(z_flag), .run(run),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .phase(phase), .IncPC(IncPC), .LoadPC(LoadPC), .LoadA(LoadA),
        .LoadFlags(LoadFlags), .LoadOut(LoadOut), .S(S), .csRAM(csRAM),
        .weRAM(weRAM), .oeOprnd(oeOprnd), .oeALU(oeALU), .oeIN(oeIN),
        .state(state)
    );

    always #5 clock = ~clock;

    assign obs = {state, phase, IncPC, LoadPC, LoadA, LoadFlags, LoadOut,
                  S, csRAM, weRAM, oeOprnd, oeALU, oeIN};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s op=%h got=%h exp=%h at %0t", tag, instr, got, exp, $time);
        end
    endtask

    function automatic bit is_mem(input logic [3:0] op);
        return op inside {4'h3, 4'h6, 4'h7, 4'hB, 4'hF};
    endfunction

    // Expected output vector for a cycle of the given kind (00 idle, 01 fetch,
    // 10 wait, 11 execute) for an opcode and the flags seen in that cycle.
    function automatic logic [15:0] model(input logic [1:0] st, input logic [3:0] op,
                                          input logic c, input logic z);
        logic inc, lpc, la, lf, lo, cs, we, oo, oa, oi, act, ex, take;
        logic [2:0] s;
        {inc, lpc, la, lf, lo, cs, we, oo, oa, oi} = '0;
        s    = 3'b000;
        act  = (st == 2'b10) || (st == 2'b11);
        ex   = (st == 2'b11);
        take = 1'b0;
        if (act) begin
            case (op)
                4'h2: begin oo = 1; s = 3'd1; lf = ex; end
                4'h3: begin cs = 1; s = 3'd1; lf = ex; end
                4'h4: begin oo = 1; la = ex; end
                4'h5: begin oi = 1; la = ex; end
                4'h6: begin cs = 1; la = ex; end
                4'h7: begin cs = 1; we = 1; oa = 1; s = 3'd4; end
                4'hA: begin oo = 1; s = 3'd2; la = ex; lf = ex; end
                4'hB: begin cs = 1; s = 3'd2; la = ex; lf = ex; end
                4'hD: begin oa = 1; s = 3'd4; lo = ex; end
                4'hE: begin oo = 1; s = 3'd3; la = ex; end
                4'hF: begin cs = 1; s = 3'd3; la = ex; end
                default: ;
            endcase
        end
        take = (op == 4'h0 && c) || (op == 4'h1 && !c) || (op == 4'h8 && z) ||
               (op == 4'h9 && !z) || (op == 4'hC);
        if (ex) begin
            lpc = take;
            inc = !take;
        end
        return {st, act, inc, lpc, la, lf, lo, s, cs, we, oo, oa, oi};
    endfunction

    task automatic rnd_flags();
        c_flag = 1'($urandom);
        z_flag = 1'($urandom);
    endtask

    // Starts at a negedge in IDLE or EXEC; runs one instruction. Ends at the
    // EXEC negedge when continuing, or at an IDLE negedge when halting.
    task automatic do_instr(input logic [3:0] op, input logic run_mid, input logic run_end);
        int nw;
        instr = op;
        run   = 1'b1;
        rnd_flags();
        @(posedge clock); @(negedge clock);
        check_eq("fetch", obs, model(2'b01, op, c_flag, z_flag));
        run = run_mid;
        rnd_flags();
        nw = is_mem(op) ? RW : 0;
        for (int w = 0; w < nw; w++) begin
            @(posedge clock); @(negedge clock);
            check_eq("mwait", obs, model(2'b10, op, c_flag, z_flag));
            run = run_mid;
            rnd_flags();
        end
        @(posedge clock); @(negedge clock);
        check_eq("exec", obs, model(2'b11, op, c_flag, z_flag));
        run = run_end;
        if (!run_end) begin
            @(posedge clock); @(negedge clock);
            check_eq("halt_idle", obs, 16'h0000);
            @(posedge clock); @(negedge clock);
            check_eq("stay_idle", obs, 16'h0000);
        end
    endtask

    initial begin
        @(negedge clock);
        check_eq("reset_state", obs, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("idle_no_run", obs, 16'h0000);

        do_instr(4'h4, 1'b1, 1'b1);
        do_instr(4'h4, 1'b1, 1'b1);
        do_instr(4'h6, 1'b1, 1'b1);
        do_instr(4'h7, 1'b0, 1'b1);
        do_instr(4'hC, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++)
            for (int op = 0; op < 16; op++)
                do_instr(4'(op), 1'($urandom), 1'b1);
        do_instr(4'hB, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a wait state.
        instr = 4'h6;
        run   = 1'b1;
        @(posedge clock); @(negedge clock);
        check_eq("pre_rst_fetch", obs, model(2'b01, 4'h6, c_flag, z_flag));
        @(posedge clock); @(negedge clock);
        check_eq("pre_rst_mwait", obs, model(2'b10, 4'h6, c_flag, z_flag));
        reset = 1'b1;
        run   = 1'b0;
        #1;
        check_eq("rst_async", obs, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("post_rst_idle", obs, 16'h0000);
        do_instr(4'h6, 1'b1, 1'b1);

        for (int n = 0; n < 60; n++)
            do_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        do_instr(4'h4, 1'b1, 1'b0);

`ifdef SINGLE_STEP_EN
        // Held step: one instruction, then idle despite step staying high.
        instr = 4'hA;
        run   = 1'b0;
        step  = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clock); @(negedge clock);
            check_eq("step_hold", obs,
                     model((cyc == 0) ? 2'b01 : (cyc == 1) ? 2'b11 : 2'b00,
                           4'hA, c_flag, z_flag));
        end
        step = 1'b0;
        @(posedge clock); @(negedge clock);
        check_eq("step_low", obs, 16'h0000);
        step  = 1'b1;
        instr = 4'h3;
        for (int cyc = 0; cyc < 2 + RW + 1; cyc++) begin
            @(posedge clock); @(negedge clock);
            check_eq("step_again", obs,
                     model((cyc == 0) ? 2'b01 : (cyc <= RW) ? 2'b10 :
                           (cyc == RW + 1) ? 2'b11 : 2'b00, 4'h3, c_flag, z_flag));
        end
        step = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
